branch_predict_resolve: RTL and testbench

// Registered EX->MEM branch resolution unit. Successor to the combinational branch-condition decoder.
// - Evaluates the 3-bit branch op against the ALU flags.
// - Holds a BHT_DEPTH-entry table of 2-bit saturating counters.
// - Gives fetch a combinational taken-prediction.
// - Registers taken / set-rd / mispredict / redirect-PC for the next stage.
// - Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_resolve_pkg.sv | 22 ++
 rtl/sat_counter_table.sv | 36 +++
 rtl/branch_predict_resolve.sv | 129 ++++++++++++
 tb/tb_branch_predict_resolve.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch-op encodings and predictor constants, common to decode, ALU and resolve.
// Pure definitions: no latency and no flow control of its own.
package branch_predict_resolve_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JUMP = 3'b001;
    localparam logic [2:0] BR_BEQZ = 3'b010;
    localparam logic [2:0] BR_BNEZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;
    localparam logic [2:0] BR_BSCO = 3'b110;
    localparam logic [2:0] BR_BLEZ = 3'b111;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    // Only conditional branches train the predictor; jumps and set-on-condition do not.
    function automatic logic isCondBranch(input logic [2:0] op);
        return op inside {BR_BEQZ, BR_BNEZ, BR_BLTZ, BR_BGEZ, BR_BLEZ};
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2-bit saturating counters: combinational MSB read, one inc/dec write per cycle.
// Read returns the pre-write value in the cycle of a write; no backpressure.
module sat_counter_table
    import branch_predict_resolve_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rdIdx,
    output logic             rdTaken,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrInc
);

    logic [1:0] cnt [DEPTH];

    assign rdTaken = cnt[rdIdx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= BHT_INIT;
            end
        end else if (wrEn) begin
            if (wrInc && cnt[wrIdx] != 2'b11) begin
                cnt[wrIdx] <= cnt[wrIdx] + 2'd1;
            end else if (!wrInc && cnt[wrIdx] != 2'b00) begin
                cnt[wrIdx] <= cnt[wrIdx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX->MEM branch resolution with 2-bit BHT prediction and saturating stats; 1-cycle EX->res latency.
// stall holds the result register and blocks BHT/stat updates; flush kills the EX instruction.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16,
    parameter int SIGNED_LT = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   f_pc,
    output logic              f_pred_taken,
    input  logic              ex_valid,
    input  logic [2:0]        ex_branch,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic              sf,
    input  logic              zf,
    input  logic              of,
    input  logic              cf,
    input  logic              stall,
    input  logic              flush,
    input  logic              stat_clr,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_setrd,
    output logic              res_mispredict,
    output logic [PC_W-1:0]   res_redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic            lt;
    logic            taken;
    logic            setRd;
    logic            mispred;
    logic            ld;
    logic            bhtWrEn;
    logic [PC_W-1:0] seqPc;
    logic            unusedFpcBits;

    // Instructions are 2 bytes, so bit 0 and the bits above the index never select an entry.
    assign unusedFpcBits = ^{f_pc[PC_W-1:IDX_W+1], f_pc[0]};

    always_comb begin
        lt    = (SIGNED_LT != 0) ? (sf ^ of) : sf;
        taken = 1'b0;
        setRd = 1'b0;
        case (ex_branch)
            BR_JUMP: taken = 1'b1;
            BR_BEQZ: begin
                taken = zf;
                setRd = zf;
            end
            BR_BNEZ: taken = ~zf;
            BR_BLTZ: begin
                taken = lt;
                setRd = lt;
            end
            BR_BGEZ: begin
                taken = ~lt | zf;
                setRd = lt | zf;
            end
            BR_BSCO: setRd = cf;
            BR_BLEZ: taken = lt | zf;
            default: ;
        endcase
    end

    assign mispred = taken ^ ex_pred_taken;
    assign seqPc   = ex_pc + PC_W'(2);
    assign ld      = ex_valid & ~stall & ~flush & (ex_branch != BR_NONE);
    assign bhtWrEn = ld & isCondBranch(ex_branch);

    sat_counter_table #(
        .DEPTH (BHT_DEPTH)
    ) uBht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdIdx   (f_pc[IDX_W:1]),
        .rdTaken (f_pred_taken),
        .wrEn    (bhtWrEn),
        .wrIdx   (ex_pc[IDX_W:1]),
        .wrInc   (taken)
    );

    // Flush only drops valid; the payload is don't-care once valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_setrd       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
        end else if (flush) begin
            res_valid       <= 1'b0;
        end else if (!stall) begin
            res_valid       <= ex_valid & (ex_branch != BR_NONE);
            res_taken       <= taken;
            res_setrd       <= setRd;
            res_mispredict  <= mispred;
            res_redirect_pc <= taken ? ex_target : seqPc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (stat_clr) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (ld) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (mispred && stat_mispred != STAT_MAX) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench: two DUTs (SIGNED_LT=1/STAT_W=16 and SIGNED_LT=0/STAT_W=4) against a spec-level model,
// plus a vector table and hand sequences for stall/flush/saturation/reset corners.
module tb_branch_predict_resolve;

    logic        clk;
    logic        rst_n;
    logic [15:0] f_pc;
    logic        ex_valid;
    logic [2:0]  ex_branch;
    logic [15:0] ex_pc;
    logic [15:0] ex_target;
    logic        ex_pred_taken;
    logic        sf, zf, of, cf;
    logic        stall, flush, stat_clr;

    logic        predA, valA, tkA, srA, misA;
    logic [15:0] redA, brA, mpA;
    logic        predB, valB, tkB, srB, misB;
    logic [15:0] redB;
    logic [3:0]  brB, mpB;

    branch_predict_resolve #(.PC_W(16), .BHT_DEPTH(16), .SIGNED_LT(1), .STAT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(predA),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .sf(sf), .zf(zf), .of(of), .cf(cf),
        .stall(stall), .flush(flush), .stat_clr(stat_clr),
        .res_valid(valA), .res_taken(tkA), .res_setrd(srA), .res_mispredict(misA),
        .res_redirect_pc(redA), .stat_branches(brA), .stat_mispred(mpA)
    );

    branch_predict_resolve #(.PC_W(16), .BHT_DEPTH(16), .SIGNED_LT(0), .STAT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(predB),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .sf(sf), .zf(zf), .of(of), .cf(cf),
        .stall(stall), .flush(flush), .stat_clr(stat_clr),
        .res_valid(valB), .res_taken(tkB), .res_setrd(srB), .res_mispredict(misB),
        .res_redirect_pc(redB), .stat_branches(brB), .stat_mispred(mpB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 models dutA, index 1 models dutB.
    int mBht [2][16];
    int mBr  [2];
    int mMp  [2];
    bit mVal [2];
    bit mTk  [2];
    bit mSr  [2];
    bit mMis [2];
    int mRed [2];

    typedef struct {
        logic [2:0]  op;
        logic        zf, sf, of, cf, pred;
        logic [15:0] pc, tgt;
        logic        eVal, eTk, eSr, eMis;
        logic [15:0] eRed;
        logic        eTkB;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) mBht[m][i] = 1;
            mBr[m] = 0; mMp[m] = 0;
            mVal[m] = 0; mTk[m] = 0; mSr[m] = 0; mMis[m] = 0; mRed[m] = 0;
        end
    endtask

    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            int op;
            int ix;
            int smax;
            bit l, tk, sr, ld;
            op   = int'(ex_branch);
            ix   = (int'(ex_pc) >> 1) % 16;
            smax = (m == 0) ? 65535 : 15;
            l    = (m == 0) ? (sf != of) : sf;
            tk   = (op == 1) || (op == 2 && zf) || (op == 3 && !zf) || (op == 4 && l) ||
                   (op == 5 && (!l || zf)) || (op == 7 && (l || zf));
            sr   = (op == 2 && zf) || (op == 4 && l) || (op == 5 && (l || zf)) || (op == 6 && cf);
            ld   = ex_valid && !stall && !flush && op != 0;
            if (flush) begin
                mVal[m] = 0;
            end else if (!stall) begin
                mVal[m] = ex_valid && op != 0;
                mTk[m]  = tk;
                mSr[m]  = sr;
                mMis[m] = (tk != ex_pred_taken);
                mRed[m] = tk ? int'(ex_target) : (int'(ex_pc) + 2) % 65536;
            end
            if (ld && op >= 2 && op != 6) begin
                if (tk && mBht[m][ix] < 3) mBht[m][ix]++;
                if (!tk && mBht[m][ix] > 0) mBht[m][ix]--;
            end
            if (stat_clr) begin
                mBr[m] = 0;
                mMp[m] = 0;
            end else if (ld) begin
                if (mBr[m] < smax) mBr[m]++;
                if (tk != ex_pred_taken && mMp[m] < smax) mMp[m]++;
            end
        end
    endtask

    task automatic cmpRes(input int m, input logic v, input logic tk, input logic sr, input logic mis,
                          input logic [15:0] red, input logic [15:0] br, input logic [15:0] mp);
        chk($sformatf("res_valid[%0d]", m), v, mVal[m]);
        chk($sformatf("res_taken[%0d]", m), tk, mTk[m]);
        chk($sformatf("res_setrd[%0d]", m), sr, mSr[m]);
        chk($sformatf("res_mispredict[%0d]", m), mis, mMis[m]);
        chk($sformatf("res_redirect_pc[%0d]", m), red, mRed[m]);
        chk($sformatf("stat_branches[%0d]", m), br, mBr[m]);
        chk($sformatf("stat_mispred[%0d]", m), mp, mMp[m]);
    endtask

    // Called just after a negedge with inputs set; returns at the following negedge.
    task automatic tick();
        #1;
        chk("f_pred_taken[0]", predA, mBht[0][(int'(f_pc) >> 1) % 16] >= 2);
        chk("f_pred_taken[1]", predB, mBht[1][(int'(f_pc) >> 1) % 16] >= 2);
        modelStep();
        @(posedge clk);
        #1;
        cmpRes(0, valA, tkA, srA, misA, redA, brA, mpA);
        cmpRes(1, valB, tkB, srB, misB, redB, 16'(brB), 16'(mpB));
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 0; ex_branch = 3'd0; stall = 0; flush = 0; stat_clr = 0;
        sf = 0; zf = 0; of = 0; cf = 0; ex_pred_taken = 0;
    endtask

    task automatic setEx(input logic [2:0] op, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic pred);
        ex_valid = 1; ex_branch = op; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    task automatic resetCheck();
        rst_n = 0;
        #1;
        modelReset();
        chk("rst res_valid", {valA, valB}, 2'b00);
        chk("rst res_taken", {tkA, tkB}, 2'b00);
        chk("rst res_setrd", {srA, srB}, 2'b00);
        chk("rst res_mispredict", {misA, misB}, 2'b00);
        chk("rst res_redirect_pc", {redA, redB}, 32'h0);
        chk("rst stats", {brA, mpA, brB, mpB}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            f_pc = 16'(i * 2);
            #1;
            chk($sformatf("rst f_pred idx%0d", i), {predA, predB}, 2'b00);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid      = ($urandom_range(0, 9) < 8);
            ex_branch     = 3'($urandom_range(0, 7));
            ex_pc         = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 63));
            ex_target     = 16'($urandom);
            ex_pred_taken = 1'($urandom_range(0, 1));
            {sf, zf, of, cf} = 4'($urandom_range(0, 15));
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            stat_clr      = ($urandom_range(0, 19) == 0);
            f_pc          = ($urandom_range(0, 1) == 0) ? ex_pc : 16'($urandom);
            tick();
        end
    endtask

    int bnezCnt [7];
    int brSnap;
    int mpSnap;

    initial begin
        //            op  zf sf of cf pr pc        tgt       val tk sr mis red     tkB
        vecs[0]  = '{3'd1, 0, 0, 0, 0, 0, 16'h0100, 16'h0200, 1, 1, 0, 1, 16'h0200, 1};
        vecs[1]  = '{3'd2, 1, 0, 0, 0, 1, 16'h0100, 16'h0200, 1, 1, 1, 0, 16'h0200, 1};
        vecs[2]  = '{3'd2, 0, 0, 0, 0, 0, 16'h0100, 16'h0200, 1, 0, 0, 0, 16'h0102, 0};
        vecs[3]  = '{3'd3, 0, 0, 0, 0, 1, 16'h0100, 16'h0200, 1, 1, 0, 0, 16'h0200, 1};
        vecs[4]  = '{3'd4, 0, 1, 0, 0, 0, 16'h0100, 16'h0200, 1, 1, 1, 1, 16'h0200, 1};
        vecs[5]  = '{3'd4, 0, 1, 1, 0, 0, 16'h0100, 16'h0200, 1, 0, 0, 0, 16'h0102, 1};
        vecs[6]  = '{3'd5, 0, 1, 0, 0, 1, 16'h0100, 16'h0200, 1, 0, 1, 1, 16'h0102, 0};
        vecs[7]  = '{3'd5, 1, 0, 0, 0, 0, 16'h0100, 16'h0200, 1, 1, 1, 1, 16'h0200, 1};
        vecs[8]  = '{3'd6, 0, 0, 0, 1, 1, 16'h0100, 16'h0200, 1, 0, 1, 1, 16'h0102, 0};
        vecs[9]  = '{3'd7, 0, 0, 1, 0, 1, 16'h0100, 16'h0200, 1, 1, 0, 0, 16'h0200, 0};
        vecs[10] = '{3'd0, 0, 0, 0, 0, 1, 16'h0100, 16'h0200, 0, 0, 0, 1, 16'h0102, 0};
        vecs[11] = '{3'd2, 0, 0, 0, 0, 0, 16'hFFFE, 16'h0200, 1, 0, 0, 0, 16'h0000, 0};
        bnezCnt = '{2, 3, 3, 3, 2, 1, 0};

        rst_n = 0; f_pc = 16'h0; ex_pc = 16'h0; ex_target = 16'h0;
        idle();
        @(negedge clk);
        resetCheck();

        // BEQZ taken against a not-taken prediction; BHT[8] goes 01 -> 10.
        setEx(3'd2, 16'h0010, 16'h0040, 0); zf = 1; f_pc = 16'h0010;
        tick();
        chk("beqz taken", tkA, 1'b1);
        chk("beqz mispredict", misA, 1'b1);
        chk("beqz redirect", redA, 16'h0040);
        #1;
        chk("beqz bht8 msb", predA, 1'b1);
        idle();

        // BNEZ training at index 3, then untraining.
        f_pc = 16'h0006;
        for (int i = 0; i < 7; i++) begin
            setEx(3'd3, 16'h0006, 16'h0080, 0);
            zf = (i >= 4);
            tick();
            #1;
            chk($sformatf("bnez pred step%0d", i), predA, bnezCnt[i] >= 2);
            if (i == 3) begin
                f_pc = 16'h0027;
                #1;
                chk("bnez alias idx3", predA, 1'b1);
                f_pc = 16'h0006;
            end
        end
        idle();

        for (int i = 0; i < 12; i++) begin
            setEx(vecs[i].op, vecs[i].pc, vecs[i].tgt, vecs[i].pred);
            zf = vecs[i].zf; sf = vecs[i].sf; of = vecs[i].of; cf = vecs[i].cf;
            tick();
            chk($sformatf("vec%0d valid", i), valA, vecs[i].eVal);
            chk($sformatf("vec%0d taken", i), tkA, vecs[i].eTk);
            chk($sformatf("vec%0d setrd", i), srA, vecs[i].eSr);
            chk($sformatf("vec%0d mispredict", i), misA, vecs[i].eMis);
            chk($sformatf("vec%0d redirect", i), redA, vecs[i].eRed);
            chk($sformatf("vec%0d taken_unsigned_lt", i), tkB, vecs[i].eTkB);
        end
        idle();

        // Stall holds the previous result for two cycles, then flush drops it.
        setEx(3'd2, 16'h0032, 16'h1234, 1); zf = 1;
        tick();
        brSnap = mBr[0];
        mpSnap = mMp[0];
        setEx(3'd1, 16'h0040, 16'h5678, 0); zf = 0; stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall valid held", valA, 1'b1);
            chk("stall taken held", tkA, 1'b1);
            chk("stall redirect held", redA, 16'h1234);
            chk("stall stats held", {brA, mpA}, {16'(brSnap), 16'(mpSnap)});
        end
        flush = 1;
        tick();
        chk("flush valid", valA, 1'b0);
        chk("flush stats held", {brA, mpA}, {16'(brSnap), 16'(mpSnap)});
        idle();

        // Saturation of 4-bit stats, then clear colliding with a load.
        stat_clr = 1;
        tick();
        stat_clr = 0;
        for (int i = 0; i < 16; i++) begin
            setEx(3'd1, 16'(i * 2), 16'h0300, 0);
            tick();
        end
        chk("sat branches 4b", brB, 4'd15);
        chk("sat mispred 4b", mpB, 4'd15);
        chk("count branches 16b", brA, 16'd16);
        stat_clr = 1;
        tick();
        chk("clr wins branches", {brA, 12'h0, brB}, 32'h0);
        chk("clr wins mispred", {mpA, 12'h0, mpB}, 32'h0);
        idle();

        randomCycles(400);

        // Reset asserted in the middle of a stalled, valid result.
        idle();
        setEx(3'd1, 16'h0044, 16'h0abc, 0);
        tick();
        stall = 1;
        tick();
        #2;
        resetCheck();
        idle();
        randomCycles(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
